// File: rtl/led_bounce_mode_sequencer.sv
// Button-driven LED pattern engine: bounce / count-up / count-down / hold, with debounce and step prescaler.
// Press latency DEBOUNCE_CYCLES+3 clocks to press_pulse, mode/LED update one clock later; no backpressure.
module led_bounce_mode_sequencer #(
    parameter int LED_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int STEP_CYCLES     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_button,
    input  logic [1:0]           speed_sel,
    output logic [LED_WIDTH-1:0] led_out,
    output logic [1:0]           mode,
    output logic                 press_pulse
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W  = $clog2(STEP_CYCLES * 8 + 1);
    localparam int POS_W = $clog2(LED_WIDTH);

    typedef enum logic [1:0] {
        M_BOUNCE     = 2'd0,
        M_COUNT_UP   = 2'd1,
        M_COUNT_DOWN = 2'd2,
        M_HOLD       = 2'd3
    } mode_e;

    logic                 s1_q, s1_d, s2_q, s2_d;
    logic                 stable_q, stable_d, stable_prev_q, stable_prev_d;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic                 press_q, press_d;
    logic [PS_W-1:0]      ps_cnt_q, ps_cnt_d;
    logic [PS_W-1:0]      ps_limit;
    logic                 tick;
    mode_e                mode_q, mode_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 dir_down_q, dir_down_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            press_q       <= 1'b0;
            ps_cnt_q      <= '0;
            mode_q        <= M_BOUNCE;
            led_q         <= {{(LED_WIDTH-1){1'b0}}, 1'b1};
            pos_q         <= '0;
            dir_down_q    <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            db_cnt_q      <= db_cnt_d;
            press_q       <= press_d;
            ps_cnt_q      <= ps_cnt_d;
            mode_q        <= mode_d;
            led_q         <= led_d;
            pos_q         <= pos_d;
            dir_down_q    <= dir_down_d;
        end
    end

    // >= rather than == so a speed increase mid-count ticks at once instead of wrapping
    assign ps_limit = PS_W'(STEP_CYCLES) << speed_sel;
    assign tick     = (ps_cnt_q >= (ps_limit - PS_W'(1)));

    always_comb begin
        s1_d          = push_button;
        s2_d          = s1_q;
        stable_d      = stable_q;
        db_cnt_d      = '0;
        stable_prev_d = stable_q;
        press_d       = stable_q & ~stable_prev_q;
        ps_cnt_d      = tick ? '0 : ps_cnt_q + PS_W'(1);
        mode_d        = mode_q;
        led_d         = led_q;
        pos_d         = pos_q;
        dir_down_d    = dir_down_q;

        if (s2_q != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // A press takes priority over a coincident tick
        if (press_q) begin
            ps_cnt_d = '0;
            unique case (mode_q)
                M_BOUNCE: begin
                    mode_d = M_COUNT_UP;
                    led_d  = '0;
                end
                M_COUNT_UP: begin
                    mode_d = M_COUNT_DOWN;
                    led_d  = '1;
                end
                M_COUNT_DOWN: begin
                    mode_d = M_HOLD;
                end
                M_HOLD: begin
                    mode_d     = M_BOUNCE;
                    pos_d      = '0;
                    dir_down_d = 1'b0;
                    led_d      = {{(LED_WIDTH-1){1'b0}}, 1'b1};
                end
                default: mode_d = M_BOUNCE;
            endcase
        end else if (tick) begin
            unique case (mode_q)
                M_BOUNCE: begin
                    if (!dir_down_q) begin
                        if (pos_q == POS_W'(LED_WIDTH - 1)) begin
                            dir_down_d = 1'b1;
                            pos_d      = POS_W'(LED_WIDTH - 2);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_down_d = 1'b0;
                            pos_d      = POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                    led_d = {{(LED_WIDTH-1){1'b0}}, 1'b1} << pos_d;
                end
                M_COUNT_UP:   led_d = led_q + LED_WIDTH'(1);
                M_COUNT_DOWN: led_d = led_q - LED_WIDTH'(1);
                M_HOLD:       led_d = led_q;
                default:      led_d = led_q;
            endcase
        end
    end

    assign led_out     = led_q;
    assign mode        = mode_q;
    assign press_pulse = press_q;

endmodule

// File: tb/tb_led_bounce_mode_sequencer.sv
// Randomised bench for led_bounce_mode_sequencer against a behavioural model of the LED engine.
module tb_led_bounce_mode_sequencer;

    localparam int W    = 8;
    localparam int DEB  = 8;
    localparam int STEP = 4;
    localparam int PER  = 2 * (W - 1);
    localparam int MODW = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         push_button;
    logic [1:0]   speed_sel;
    logic [W-1:0] led_out;
    logic [1:0]   mode;
    logic         press_pulse;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // model state: values visible after the most recent edge
    int m_s1, m_s2, m_stable, m_prev, m_run, m_pulse;
    int m_mode, m_led, m_pc, m_k;

    led_bounce_mode_sequencer #(
        .LED_WIDTH(W), .DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(STEP)
    ) dut (
        .clk(clk), .rst(rst), .push_button(push_button), .speed_sel(speed_sel),
        .led_out(led_out), .mode(mode), .press_pulse(press_pulse)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // bounce position as a triangle wave over the sweep phase
    function automatic int tri_pos(input int k);
        return (k <= W - 1) ? k : PER - k;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_stable = 0; m_prev = 0; m_run = 0; m_pulse = 0;
        m_mode = 0; m_led = 1; m_pc = 0; m_k = 0;
    endtask

    task automatic model_step(input int b, input int spd);
        int n_stable, n_run, n_prev, n_pulse, limit;
        bit tk;
        n_stable = m_stable;
        n_run    = 0;
        if (m_s2 != m_stable) begin
            if (m_run + 1 == DEB) n_stable = m_s2;
            else                  n_run = m_run + 1;
        end
        n_prev  = m_stable;
        n_pulse = (m_stable == 1 && m_prev == 0) ? 1 : 0;
        limit   = STEP << spd;
        tk      = (m_pc >= limit - 1);
        if (m_pulse == 1) begin
            m_mode = (m_mode + 1) % 4;
            m_pc   = 0;
            case (m_mode)
                1: m_led = 0;
                2: m_led = MODW - 1;
                0: begin m_led = 1; m_k = 0; end
                default: ;
            endcase
        end else begin
            m_pc = tk ? 0 : m_pc + 1;
            if (tk) begin
                case (m_mode)
                    0: begin m_k = (m_k + 1) % PER; m_led = 1 << tri_pos(m_k); end
                    1: m_led = (m_led + 1) % MODW;
                    2: m_led = (m_led + MODW - 1) % MODW;
                    default: ;
                endcase
            end
        end
        m_s2 = m_s1; m_s1 = b;
        m_stable = n_stable; m_run = n_run; m_prev = n_prev; m_pulse = n_pulse;
    endtask

    task automatic compare();
        chk("led_out", 32'(led_out), 32'(m_led));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("press_pulse", 32'(press_pulse), 32'(m_pulse));
        if (press_pulse === 1'b1) pulses++;
    endtask

    // called at a falling edge; drives inputs, advances one clock, checks at the next falling edge
    task automatic step(input bit b, input logic [1:0] s);
        push_button = b;
        speed_sel   = s;
        if (rst) model_reset();
        else     model_step(int'(b), int'(s));
        @(negedge clk);
        compare();
    endtask

    // reset pulse between edges; outputs must clear without a clock
    task automatic async_rst();
        #20 rst = 1'b1;
        #5;
        chk("arst_led", 32'(led_out), 32'h1);
        chk("arst_mode", 32'(mode), 32'h0);
        chk("arst_pulse", 32'(press_pulse), 32'h0);
        model_reset();
        #15 rst = 1'b0;
    endtask

    task automatic press(input int hi, input int lo, input logic [1:0] s);
        for (int i = 0; i < hi; i++) step(1'b1, s);
        for (int i = 0; i < lo; i++) step(1'b0, s);
    endtask

    initial begin
        rst = 1'b1; push_button = 1'b0; speed_sel = 2'd0;
        model_reset();
        #10;
        chk("rst_led", 32'(led_out), 32'h1);
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_pulse", 32'(press_pulse), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // idle: first tick after four clocks, then a full sweep
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0);
        chk("idle3_led", 32'(led_out), 32'h01);
        step(1'b0, 2'd0);
        chk("idle4_led", 32'(led_out), 32'h02);
        for (int i = 0; i < 60; i++) step(1'b0, 2'd0);
        chk("idle_no_press", 32'(pulses), 32'd0);

        // bouncy press: exactly one pulse, mode 0 -> 1
        pulses = 0;
        step(1'b1, 2'd0); step(1'b1, 2'd0); step(1'b0, 2'd0);
        step(1'b1, 2'd0); step(1'b0, 2'd0);
        for (int i = 0; i < 25; i++) step(1'b1, 2'd0);
        step(1'b0, 2'd0); step(1'b1, 2'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 2'd0);
        chk("bouncy_one_press", 32'(pulses), 32'd1);
        chk("bouncy_mode", 32'(mode), 32'd1);

        // count-up wrap through FF back to 00
        for (int i = 0; i < 1040; i++) step(1'b0, 2'd0);
        // into count-down, then slow speed and speed changes
        press(14, 14, 2'd0);
        chk("count_down_mode", 32'(mode), 32'd2);
        for (int i = 0; i < 100; i++) step(1'b0, 2'd3);
        for (int i = 0; i < 40; i++) step(1'b0, 2'($urandom_range(0, 3)));

        // randomised presses, speeds and async resets
        for (int seg = 0; seg < 50; seg++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            press($urandom_range(1, 30), $urandom_range(1, 30), s);
            if ($urandom_range(0, 7) == 0) begin
                push_button = 1'($urandom_range(0, 1));
                async_rst();
                for (int i = 0; i < 20; i++) step(push_button, s);
            end
        end

        // rst mid-debounce with the button held through release: one pulse after debounce
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0);
        async_rst();
        pulses = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 2'd0);
        chk("held_rst_one_press", 32'(pulses), 32'd1);
        chk("held_rst_mode", 32'(mode), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
